// File: rtl/global_defs.sv
// Shared types and constants for the DRAM command path: command encoding, address map,
// scheduler states, default DDR4 timing and the request record popped from the parser FIFO.
package global_defs;

   localparam int unsigned NUM_BANKS  = 16;
   localparam int unsigned BANK_IDX_W = 4;
   localparam int unsigned ROW_W      = 16;
   localparam int unsigned COL_W      = 11;

   localparam int unsigned ADDR_ROW_MSB    = 33;
   localparam int unsigned ADDR_ROW_LSB    = 18;
   localparam int unsigned ADDR_COL_HI_MSB = 17;
   localparam int unsigned ADDR_COL_HI_LSB = 10;
   localparam int unsigned ADDR_BANK_MSB   = 9;
   localparam int unsigned ADDR_BANK_LSB   = 8;
   localparam int unsigned ADDR_BG_MSB     = 7;
   localparam int unsigned ADDR_BG_LSB     = 6;
   localparam int unsigned ADDR_COL_LO_MSB = 5;
   localparam int unsigned ADDR_COL_LO_LSB = 3;

   localparam int unsigned DEF_T_RCD   = 24;
   localparam int unsigned DEF_T_CL    = 24;
   localparam int unsigned DEF_T_CWD   = 20;
   localparam int unsigned DEF_T_RP    = 24;
   localparam int unsigned DEF_T_RAS   = 52;
   localparam int unsigned DEF_T_BURST = 4;
   localparam int unsigned DEF_T_WR    = 20;
   localparam int unsigned DEF_T_RTP   = 12;
   localparam int unsigned DEF_CNT_W   = 8;

   typedef enum logic [2:0] {
      CmdNop = 3'd0,
      CmdAct = 3'd1,
      CmdPre = 3'd2,
      CmdRd  = 3'd3,
      CmdWr  = 3'd4
   } dram_cmd_e;

   typedef enum logic [2:0] {
      StIdle, StDecide, StPre, StPreWait, StAct, StActWait, StCas, StCasWait
   } sched_state_e;

   typedef struct packed {
      logic [31:0] CPU_clock_count;
      logic [1:0]  opcode;
      logic [33:0] address;
   } parser_out_struct;

endpackage

// File: rtl/dram_bank_tracker.sv
// Open-row table for all banks plus a per-bank "earliest PRE" countdown. Counters hold
// (remaining DRAM edges - 1), so a zero count means PRE may issue on the current DRAM edge.
module dram_bank_tracker
   import global_defs::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                  CPU_clock,
   input  logic                  rst,
   input  logic                  tick,
   input  logic [BANK_IDX_W-1:0] lookup_bank,
   input  logic [ROW_W-1:0]      lookup_row,
   output logic                  hit,
   output logic                  closed,
   output logic                  conflict,
   output logic                  pre_ok,
   input  logic                  upd_valid,
   input  dram_cmd_e             upd_cmd,
   input  logic [BANK_IDX_W-1:0] upd_bank,
   input  logic [ROW_W-1:0]      upd_row,
   input  logic [CNT_W-1:0]      upd_cnt
);

   logic [NUM_BANKS-1:0] open_q, open_d;
   logic [ROW_W-1:0]     row_q [NUM_BANKS];
   logic [ROW_W-1:0]     row_d [NUM_BANKS];
   logic [CNT_W-1:0]     cnt_q [NUM_BANKS];
   logic [CNT_W-1:0]     cnt_d [NUM_BANKS];
   logic [CNT_W-1:0]     dec   [NUM_BANKS];

   always_comb begin
      for (int i = 0; i < NUM_BANKS; i++) begin
         open_d[i] = open_q[i];
         row_d[i]  = row_q[i];
         dec[i]    = (tick && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
         cnt_d[i]  = dec[i];
         // A load on a ticking edge keeps whichever constraint ends later.
         if (upd_valid && upd_bank == BANK_IDX_W'(i)) begin
            case (upd_cmd)
               CmdAct: begin
                  open_d[i] = 1'b1;
                  row_d[i]  = upd_row;
                  cnt_d[i]  = (dec[i] > upd_cnt) ? dec[i] : upd_cnt;
               end
               CmdPre: open_d[i] = 1'b0;
               CmdRd, CmdWr: cnt_d[i] = (dec[i] > upd_cnt) ? dec[i] : upd_cnt;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         open_q <= '0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            row_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         open_q <= open_d;
         row_q  <= row_d;
         cnt_q  <= cnt_d;
      end
   end

   assign closed   = !open_q[lookup_bank];
   assign hit      = open_q[lookup_bank] && (row_q[lookup_bank] == lookup_row);
   assign conflict = open_q[lookup_bank] && (row_q[lookup_bank] != lookup_row);
   assign pre_ok   = (cnt_q[lookup_bank] == '0);

endmodule

// File: rtl/dram_cmd_scheduler.sv
// In-order DRAM command scheduler: pops one request, opens/closes rows as needed and issues
// ACT/PRE/RD/WR on DRAM edges (every other CPU cycle) with the configured timing gaps.
module dram_cmd_scheduler
   import global_defs::*;
#(
   parameter int unsigned T_RCD   = DEF_T_RCD,
   parameter int unsigned T_CL    = DEF_T_CL,
   parameter int unsigned T_CWD   = DEF_T_CWD,
   parameter int unsigned T_RP    = DEF_T_RP,
   parameter int unsigned T_RAS   = DEF_T_RAS,
   parameter int unsigned T_BURST = DEF_T_BURST,
   parameter int unsigned T_WR    = DEF_T_WR,
   parameter int unsigned T_RTP   = DEF_T_RTP,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                   CPU_clock,
   input  logic                   rst,
   input  parser_out_struct       fifo_output,
   input  logic                   empty,
   output logic                   exit_flag,
   output logic                   cmd_valid,
   output dram_cmd_e              cmd,
   output logic [1:0]             cmd_bg,
   output logic [1:0]             cmd_bank,
   output logic [ROW_W-1:0]       cmd_row,
   output logic [COL_W-1:0]       cmd_col,
   output logic                   busy
);

   sched_state_e     state_q, state_d;
   logic             phase_q;
   parser_out_struct req_q;
   logic [CNT_W-1:0] wait_q, wait_load, upd_cnt;
   logic [1:0]       bg_q, bank_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic [1:0]       req_bg, req_bank;
   logic [ROW_W-1:0] req_row;
   logic [COL_W-1:0] req_col;
   logic             req_is_rd, req_is_wr;
   logic             hit, closed, conflict, pre_ok;
   dram_cmd_e        issue_cmd;
   logic             unused_bits;

   assign req_row   = req_q.address[ADDR_ROW_MSB:ADDR_ROW_LSB];
   assign req_bg    = req_q.address[ADDR_BG_MSB:ADDR_BG_LSB];
   assign req_bank  = req_q.address[ADDR_BANK_MSB:ADDR_BANK_LSB];
   assign req_col   = {req_q.address[ADDR_COL_HI_MSB:ADDR_COL_HI_LSB],
                       req_q.address[ADDR_COL_LO_MSB:ADDR_COL_LO_LSB]};
   assign req_is_rd = (req_q.opcode == 2'd0) || (req_q.opcode == 2'd2);
   assign req_is_wr = (req_q.opcode == 2'd1);
   assign unused_bits = ^{req_q.CPU_clock_count, req_q.address[2:0]};

   dram_bank_tracker #(
      .CNT_W (CNT_W)
   ) u_tracker (
      .CPU_clock   (CPU_clock),
      .rst         (rst),
      .tick        (phase_q),
      .lookup_bank ({req_bg, req_bank}),
      .lookup_row  (req_row),
      .hit         (hit),
      .closed      (closed),
      .conflict    (conflict),
      .pre_ok      (pre_ok),
      .upd_valid   (cmd_valid),
      .upd_cmd     (issue_cmd),
      .upd_bank    ({req_bg, req_bank}),
      .upd_row     (req_row),
      .upd_cnt     (upd_cnt)
   );

   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Wait states leave on the CPU cycle before the target DRAM edge, so the follow-on
   // command lands exactly N DRAM cycles after the one that loaded the wait.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (!empty && phase_q) state_d = StDecide;
         StDecide: begin
            if (!(req_is_rd || req_is_wr)) state_d = StIdle;
            else if (hit)                  state_d = StCas;
            else if (closed)               state_d = StAct;
            else if (conflict)             state_d = StPre;
         end
         StPre:     if (phase_q && pre_ok)         state_d = StPreWait;
         StPreWait: if (!phase_q && wait_q == '0) state_d = StAct;
         StAct:     if (phase_q)                   state_d = StActWait;
         StActWait: if (!phase_q && wait_q == '0) state_d = StCas;
         StCas:     if (phase_q)                   state_d = StCasWait;
         StCasWait: if (!phase_q && wait_q == '0) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      exit_flag = (state_q == StIdle) && !empty && phase_q;
      busy      = (state_q != StIdle);
      issue_cmd = CmdNop;
      if (phase_q) begin
         case (state_q)
            StPre:   if (pre_ok) issue_cmd = CmdPre;
            StAct:   issue_cmd = CmdAct;
            StCas:   issue_cmd = req_is_wr ? CmdWr : CmdRd;
            default: ;
         endcase
      end
      cmd_valid = (issue_cmd != CmdNop);
      cmd       = issue_cmd;
      cmd_bg    = cmd_valid ? req_bg   : bg_q;
      cmd_bank  = cmd_valid ? req_bank : bank_q;
      cmd_row   = cmd_valid ? req_row  : row_q;
      cmd_col   = cmd_valid ? req_col  : col_q;
   end

   always_comb begin
      wait_load = '0;
      upd_cnt   = '0;
      case (issue_cmd)
         CmdPre: wait_load = CNT_W'(T_RP - 1);
         CmdAct: begin
            wait_load = CNT_W'(T_RCD - 1);
            upd_cnt   = CNT_W'(T_RAS - 1);
         end
         CmdRd: begin
            wait_load = CNT_W'(T_CL + T_BURST - 1);
            upd_cnt   = CNT_W'(T_RTP - 1);
         end
         CmdWr: begin
            wait_load = CNT_W'(T_CWD + T_BURST - 1);
            upd_cnt   = CNT_W'(T_CWD + T_BURST + T_WR - 1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         phase_q <= 1'b0;
         req_q   <= '0;
         wait_q  <= '0;
         bg_q    <= '0;
         bank_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         phase_q <= ~phase_q;
         if (exit_flag) req_q <= fifo_output;
         if (cmd_valid) begin
            wait_q <= wait_load;
            bg_q   <= req_bg;
            bank_q <= req_bank;
            row_q  <= req_row;
            col_q  <= req_col;
         end else if (phase_q && wait_q != '0) begin
            wait_q <= wait_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: a queue-backed FIFO feeds requests, a monitor logs
// pops and commands with CPU-cycle stamps, and timing gaps are checked against hand values.
module tb_dram_cmd_scheduler;
   import global_defs::*;

   logic             CPU_clock, rst, empty, exit_flag, cmd_valid, busy;
   parser_out_struct fifo_output;
   dram_cmd_e        cmd;
   logic [1:0]       cmd_bg, cmd_bank;
   logic [15:0]      cmd_row;
   logic [10:0]      cmd_col;

   typedef struct {
      int          cyc;
      dram_cmd_e   cmd;
      logic [1:0]  bg;
      logic [1:0]  bank;
      logic [15:0] row;
      logic [10:0] col;
   } ev_t;

   int               cyc = 0;
   int               n_checks = 0;
   int               n_errors = 0;
   ev_t              evq[$];
   int               pops[$];
   int               falls[$];
   parser_out_struct fq[$];
   logic             prev_busy = 1'b0;
   ev_t              e0, e1, e2, e3, e4;

   dram_cmd_scheduler dut (
      .CPU_clock   (CPU_clock),
      .rst         (rst),
      .fifo_output (fifo_output),
      .empty       (empty),
      .exit_flag   (exit_flag),
      .cmd_valid   (cmd_valid),
      .cmd         (cmd),
      .cmd_bg      (cmd_bg),
      .cmd_bank    (cmd_bank),
      .cmd_row     (cmd_row),
      .cmd_col     (cmd_col),
      .busy        (busy)
   );

   initial CPU_clock = 1'b0;
   always #5 CPU_clock = ~CPU_clock;
   always @(posedge CPU_clock) cyc <= cyc + 1;

   always @(negedge CPU_clock) begin
      if (cmd_valid)
         evq.push_back('{cyc: cyc, cmd: cmd, bg: cmd_bg, bank: cmd_bank, row: cmd_row,
                         col: cmd_col});
      if (exit_flag) pops.push_back(cyc);
      if (prev_busy && !busy) falls.push_back(cyc);
      prev_busy <= busy;
   end

   // FIFO model: the head is retired just after the edge on which exit_flag was high.
   initial begin
      logic ef;
      empty = 1'b1;
      fifo_output = '0;
      forever begin
         @(negedge CPU_clock);
         ef = exit_flag;
         @(posedge CPU_clock);
         #1;
         if (ef && fq.size() != 0) fq.delete(0);
         empty = (fq.size() == 0);
         if (fq.size() != 0) fifo_output = fq[0];
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic ev_t ev_at(input int i);
      ev_t e;
      e = '{cyc: -100000, cmd: CmdNop, bg: '0, bank: '0, row: '0, col: '0};
      if (i < evq.size()) e = evq[i];
      return e;
   endfunction

   function automatic int pop_at(input int i);
      return (i < pops.size()) ? pops[i] : -100000;
   endfunction

   function automatic int fall_at(input int i);
      return (i < falls.size()) ? falls[i] : -100000;
   endfunction

   task automatic push_req(input logic [1:0] op, input logic [33:0] addr);
      parser_out_struct r;
      r.CPU_clock_count = 32'(cyc);
      r.opcode = op;
      r.address = addr;
      fq.push_back(r);
   endtask

   task automatic clear_logs();
      evq.delete();
      pops.delete();
      falls.delete();
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((fq.size() != 0 || busy) && n < 3000) begin
         @(negedge CPU_clock);
         n++;
      end
      check_eq(tag, 64'(n >= 3000), 64'd0);
      repeat (4) @(negedge CPU_clock);
   endtask

   task automatic grab_events();
      e0 = ev_at(0);
      e1 = ev_at(1);
      e2 = ev_at(2);
      e3 = ev_at(3);
      e4 = ev_at(4);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (4) @(negedge CPU_clock);
      #1;
      check_eq("rst_exit", exit_flag, 1'b0);
      check_eq("rst_valid", cmd_valid, 1'b0);
      check_eq("rst_cmd", cmd, CmdNop);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col}, '0);
      @(negedge CPU_clock);
      rst = 1'b0;
      repeat (3) @(negedge CPU_clock);

      // Cold read to bank 0 row 0, then a same-row read (col_hi = 1 -> col = 8).
      clear_logs();
      push_req(2'd0, 34'h0_0000_0000);
      push_req(2'd2, 34'h0_0000_0400);
      wait_idle("a_timeout");
      grab_events();
      check_eq("a_nev", evq.size(), 3);
      check_eq("a_npop", pops.size(), 2);
      check_eq("a_act_cmd", e0.cmd, CmdAct);
      check_eq("a_act_lat", e0.cyc - pop_at(0), 2);
      check_eq("a_act_addr", {e0.bg, e0.bank, e0.row}, '0);
      check_eq("a_rd_cmd", e1.cmd, CmdRd);
      check_eq("a_rd_gap", e1.cyc - e0.cyc, 48);
      check_eq("a_busy_fall", fall_at(0) - e1.cyc, 56);
      check_eq("a_hit_cmd", e2.cmd, CmdRd);
      check_eq("a_hit_lat", e2.cyc - pop_at(1), 2);
      check_eq("a_hit_col", e2.col, 11'd8);

      // Row conflict in bg1 straight after the row-0 read; RAS is already covered
      // when the conflict reaches PRE (pop at ACT+104, PRE two cycles later).
      clear_logs();
      push_req(2'd0, 34'h0_0000_0040);
      push_req(2'd0, 34'h0_0004_0040);
      wait_idle("b_timeout");
      grab_events();
      check_eq("b_nev", evq.size(), 5);
      check_eq("b_act0_bg", {e0.cmd, e0.bg, e0.row}, {CmdAct, 2'd1, 16'd0});
      check_eq("b_pre_cmd", {e2.cmd, e2.bg}, {CmdPre, 2'd1});
      check_eq("b_pre_gap", e2.cyc - e0.cyc, 106);
      check_eq("b_act1", {e3.cmd, e3.row}, {CmdAct, 16'd1});
      check_eq("b_act1_gap", e3.cyc - e2.cyc, 48);
      check_eq("b_rd1_gap", {e4.cmd, 32'(e4.cyc - e3.cyc)}, {CmdRd, 32'd48});

      // Write then conflict in bg2: PRE held off by write recovery, 88 after WR.
      clear_logs();
      push_req(2'd1, 34'h0_0000_0080);
      push_req(2'd0, 34'h0_0004_0080);
      wait_idle("c_timeout");
      grab_events();
      check_eq("c_nev", evq.size(), 5);
      check_eq("c_wr_cmd", {e1.cmd, e1.bg}, {CmdWr, 2'd2});
      check_eq("c_wr_gap", e1.cyc - e0.cyc, 48);
      check_eq("c_pre_cmd", e2.cmd, CmdPre);
      check_eq("c_wr_to_pre", e2.cyc - e1.cyc, 88);
      check_eq("c_act1", {e3.cmd, e3.row, 32'(e3.cyc - e2.cyc)}, {CmdAct, 16'd1, 32'd48});

      // Bank 0 hit, then bank 1 opens right after it completes.
      clear_logs();
      push_req(2'd0, 34'h0_0000_0000);
      push_req(2'd0, 34'h0_0000_0100);
      wait_idle("d_timeout");
      grab_events();
      check_eq("d_rd0", {e0.cmd, e0.bank}, {CmdRd, 2'd0});
      check_eq("d_act1", {e1.cmd, e1.bank}, {CmdAct, 2'd1});
      check_eq("d_act1_gap", e1.cyc - e0.cyc, 58);
      check_eq("d_act1_lat", e1.cyc - pop_at(1), 2);

      // Unknown opcode is popped and dropped; the next request follows two cycles later.
      clear_logs();
      push_req(2'd3, 34'h0_0004_0000);
      push_req(2'd0, 34'h0_0000_0100);
      wait_idle("e_timeout");
      grab_events();
      check_eq("e_nev", evq.size(), 1);
      check_eq("e_pop_gap", pop_at(1) - pop_at(0), 2);
      check_eq("e_rd", {e0.cmd, e0.bank, 32'(e0.cyc - pop_at(1))}, {CmdRd, 2'd1, 32'd2});

      // Reset in the ACT->RD wait, then the same address must re-open the row.
      clear_logs();
      push_req(2'd0, 34'h0_0008_0300);
      n = 0;
      while (evq.size() == 0 && n < 200) begin
         @(negedge CPU_clock);
         n++;
      end
      check_eq("f_act_seen", 64'(n >= 200), 64'd0);
      grab_events();
      check_eq("f_act0", {e0.cmd, e0.bank, e0.row}, {CmdAct, 2'd3, 16'd2});
      repeat (10) @(negedge CPU_clock);
      rst = 1'b1;
      #1;
      check_eq("f_rst_strobes", {exit_flag, cmd_valid, busy}, 3'b000);
      check_eq("f_rst_cmd", cmd, CmdNop);
      check_eq("f_rst_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col}, '0);
      repeat (2) @(negedge CPU_clock);
      rst = 1'b0;
      repeat (3) @(negedge CPU_clock);
      clear_logs();
      push_req(2'd0, 34'h0_0008_0300);
      wait_idle("f_timeout");
      grab_events();
      check_eq("f_nev", evq.size(), 2);
      check_eq("f_reopen", {e0.cmd, e0.bank, e0.row}, {CmdAct, 2'd3, 16'd2});
      check_eq("f_rd", {e1.cmd, 32'(e1.cyc - e0.cyc)}, {CmdRd, 32'd48});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
